// File: rtl/audio_pkg.sv
// Shared constants, fetch FSM encoding and small arithmetic helpers for the
// audio playback path.
package audio_pkg;

    localparam int AUDIO_DATA_W    = 16;
    localparam int AUDIO_SLOT_BITS = 32;
    localparam int AUDIO_BCLK_DIV  = 4;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_CAP  = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Frame bit driven on a falling BCLK: one-bit I2S delay, MSB first.
    function automatic logic [4:0] slot_bit_idx(input logic [4:0] bit_new);
        return 5'd31 - (bit_new - 5'd1);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK/LRCK generator: divides rd_clk into BCLK, flags each falling BCLK
// edge and tracks the 32-bit slot position within the frame.
module i2s_clk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = AUDIO_BCLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    output logic       bclk,
    output logic       lrck,
    output logic       fall,
    output logic [4:0] bit_cnt_next
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt_r;
    logic             bclk_r;
    logic             lrck_r;
    logic [4:0]       bit_cnt_r;
    logic             wrap_s;
    logic             fall_s;
    logic [4:0]       bit_next_s;

    // Divider wrap, falling-edge strobe and the slot position it will move to.
    always_comb begin
        wrap_s     = (div_cnt_r == DIV_W'(BCLK_DIV - 1));
        fall_s     = wrap_s & bclk_r;
        bit_next_s = bit_cnt_r + 5'd1;
    end

    // Divider, BCLK toggle and slot counter; LRCK follows the new slot's MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
            lrck_r    <= 1'b0;
            bit_cnt_r <= 5'd31;
        end else begin
            if (wrap_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                bclk_r    <= ~bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
            if (fall_s) begin
                bit_cnt_r <= bit_next_s;
                lrck_r    <= bit_next_s[4];
            end
        end
    end

    assign bclk         = bclk_r;
    assign lrck         = lrck_r;
    assign fall         = fall_s;
    assign bit_cnt_next = bit_next_s;

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo Philips I2S transmitter fed from the audio buffer bank.
// Build option AUDIO_I2S_TX_HOLD_LAST_EN: repeat the last sample on underrun.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = AUDIO_BCLK_DIV,
    parameter int DATA_W   = AUDIO_DATA_W
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic              play_en,
    input  logic              rd_empty,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              underrun,
    output logic [15:0]       underrun_cnt
);

    // The 5-bit slot counter addresses a 32-bit frame, so DATA_W stays 16.
    localparam int FRAME_W = 2 * DATA_W;

    logic               fall_s;
    logic [4:0]         bit_next_s;
    logic               frame_start_s;
    logic               pop_slot_s;
    logic [4:0]         sd_idx_s;
    logic [FRAME_W-1:0] fill_s;

    fetch_state_t       state_r;
    fetch_state_t       state_next_s;
    logic [DATA_W-1:0]  next_sample_r;
    logic               next_valid_r;
    logic [FRAME_W-1:0] frame_sr_r;
    logic               sdata_r;
    logic               underrun_r;
    logic [15:0]        underrun_cnt_r;
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
    logic [DATA_W-1:0]  last_sample_r;
`endif

    i2s_clk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clk_gen (
        .clk          (rd_clk),
        .rst          (rd_rst),
        .bclk         (i2s_bclk),
        .lrck         (i2s_lrck),
        .fall         (fall_s),
        .bit_cnt_next (bit_next_s)
    );

    // Frame events and the value loaded into the frame on an underrun.
    always_comb begin
        frame_start_s = fall_s && (bit_next_s == 5'd0);
        pop_slot_s    = fall_s && (bit_next_s == 5'd16);
        sd_idx_s      = slot_bit_idx(bit_next_s);
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
        fill_s        = {last_sample_r, last_sample_r};
`else
        fill_s        = {FRAME_W{1'b0}};
`endif
    end

    // Fetch FSM next state: at most one pop per frame, requested at mid-frame.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            F_IDLE: begin
                if (pop_slot_s && play_en && !rd_empty && !next_valid_r) begin
                    state_next_s = F_REQ;
                end else begin
                    state_next_s = F_IDLE;
                end
            end
            F_REQ:   state_next_s = F_CAP;
            F_CAP:   state_next_s = F_IDLE;
            default: state_next_s = F_IDLE;
        endcase
    end

    // Fetch FSM state register.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_r <= F_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Gated by reset so an abandoned request never reaches the bank.
    assign rd_en = (state_r == F_REQ) && !rd_rst;

    // Prefetch buffer: filled from the bank, drained at each frame start.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            next_sample_r <= {DATA_W{1'b0}};
            next_valid_r  <= 1'b0;
        end else if (state_r == F_CAP) begin
            next_sample_r <= rd_data;
            next_valid_r  <= 1'b1;
        end else if (frame_start_s) begin
            next_valid_r  <= 1'b0;
        end
    end

    // Frame shift source, serial data and underrun accounting.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            frame_sr_r     <= {FRAME_W{1'b0}};
            sdata_r        <= 1'b0;
            underrun_r     <= 1'b0;
            underrun_cnt_r <= 16'd0;
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
            last_sample_r  <= {DATA_W{1'b0}};
`endif
        end else begin
            underrun_r <= frame_start_s && !next_valid_r && play_en;
            if (fall_s) begin
                sdata_r <= frame_sr_r[sd_idx_s];
            end
            if (frame_start_s) begin
                if (next_valid_r) begin
                    frame_sr_r    <= {next_sample_r, next_sample_r};
`ifdef AUDIO_I2S_TX_HOLD_LAST_EN
                    last_sample_r <= next_sample_r;
`endif
                end else if (play_en) begin
                    frame_sr_r     <= fill_s;
                    underrun_cnt_r <= sat_inc16(underrun_cnt_r);
                end else begin
                    frame_sr_r     <= {FRAME_W{1'b0}};
                end
            end
        end
    end

    assign i2s_sdata    = sdata_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = underrun_cnt_r;

endmodule
